// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: loads decode fields, holds on freeze, bubbles on flush or invalid input.
// Optional performance counters (stall/bubble) are built when ID_EXE_PERF_EN is defined.
module id_exe_reg #(
  parameter int WORD_LEN     = 32,
  parameter int EXE_CMD_LEN  = 4,
  parameter int REG_ADDR_LEN = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic                    in_wb_en,
  input  logic                    in_mem_r_en,
  input  logic                    in_mem_w_en,
  input  logic [EXE_CMD_LEN-1:0]  in_exe_cmd,
  input  logic [REG_ADDR_LEN-1:0] in_dest,
  input  logic [REG_ADDR_LEN-1:0] in_src1,
  input  logic [REG_ADDR_LEN-1:0] in_src2,
  input  logic [WORD_LEN-1:0]     in_val1,
  input  logic [WORD_LEN-1:0]     in_val2,
  input  logic [WORD_LEN-1:0]     in_st_val,
  input  logic [WORD_LEN-1:0]     in_pc,
  output logic                    out_valid,
  output logic                    out_wb_en,
  output logic                    out_mem_r_en,
  output logic                    out_mem_w_en,
  output logic [EXE_CMD_LEN-1:0]  out_exe_cmd,
  output logic [REG_ADDR_LEN-1:0] out_dest,
  output logic [REG_ADDR_LEN-1:0] out_src1,
  output logic [REG_ADDR_LEN-1:0] out_src2,
  output logic [WORD_LEN-1:0]     out_val1,
  output logic [WORD_LEN-1:0]     out_val2,
  output logic [WORD_LEN-1:0]     out_st_val,
  output logic [WORD_LEN-1:0]     out_pc
`ifdef ID_EXE_PERF_EN
  ,
  input  logic                    perf_clr,
  output logic [15:0]             stall_cnt,
  output logic [15:0]             bubble_cnt
`endif
);

  typedef struct packed {
    logic                    valid;
    logic                    wb_en;
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic [EXE_CMD_LEN-1:0]  exe_cmd;
    logic [REG_ADDR_LEN-1:0] dest;
    logic [REG_ADDR_LEN-1:0] src1;
    logic [REG_ADDR_LEN-1:0] src2;
    logic [WORD_LEN-1:0]     val1;
    logic [WORD_LEN-1:0]     val2;
    logic [WORD_LEN-1:0]     st_val;
    logic [WORD_LEN-1:0]     pc;
  } stage_t;

  stage_t in_s, stage_d, stage_q;

  always_comb begin
    in_s          = '0;
    in_s.valid    = 1'b1;
    in_s.wb_en    = in_wb_en;
    in_s.mem_r_en = in_mem_r_en;
    in_s.mem_w_en = in_mem_w_en;
    in_s.exe_cmd  = in_exe_cmd;
    in_s.dest     = in_dest;
    in_s.src1     = in_src1;
    in_s.src2     = in_src2;
    in_s.val1     = in_val1;
    in_s.val2     = in_val2;
    in_s.st_val   = in_st_val;
    in_s.pc       = in_pc;
  end

  // A bubble is the all-zero stage, so side-effect enables can never leak without valid.
  always_comb begin
    stage_d = stage_q;
    if (flush)        stage_d = '0;
    else if (!freeze) stage_d = in_valid ? in_s : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign out_valid    = stage_q.valid;
  assign out_wb_en    = stage_q.wb_en;
  assign out_mem_r_en = stage_q.mem_r_en;
  assign out_mem_w_en = stage_q.mem_w_en;
  assign out_exe_cmd  = stage_q.exe_cmd;
  assign out_dest     = stage_q.dest;
  assign out_src1     = stage_q.src1;
  assign out_src2     = stage_q.src2;
  assign out_val1     = stage_q.val1;
  assign out_val2     = stage_q.val2;
  assign out_st_val   = stage_q.st_val;
  assign out_pc       = stage_q.pc;

`ifdef ID_EXE_PERF_EN
  logic [15:0] stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q;
  logic        stall_ev, bubble_ev;

  assign stall_ev  = freeze & ~flush;
  assign bubble_ev = flush | (~freeze & ~in_valid);

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (perf_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stall_ev && stall_cnt_q != 16'hFFFF)   stall_cnt_d  = stall_cnt_q + 16'd1;
      if (bubble_ev && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: behavioural model compared every cycle plus directed literal checks.
module tb_id_exe_reg;
  localparam int WL = 32, CL = 4, RL = 5;
  localparam int VW = 4 + CL + 3*RL + 4*WL;
  localparam logic [CL-1:0] ADD = 4'd1;

  logic clk = 0, rst = 1, freeze = 0, flush = 0, in_valid = 0;
  logic in_wb_en = 0, in_mem_r_en = 0, in_mem_w_en = 0;
  logic [CL-1:0] in_exe_cmd = '0;
  logic [RL-1:0] in_dest = '0, in_src1 = '0, in_src2 = '0;
  logic [WL-1:0] in_val1 = '0, in_val2 = '0, in_st_val = '0, in_pc = '0;
  logic out_valid, out_wb_en, out_mem_r_en, out_mem_w_en;
  logic [CL-1:0] out_exe_cmd;
  logic [RL-1:0] out_dest, out_src1, out_src2;
  logic [WL-1:0] out_val1, out_val2, out_st_val, out_pc;
  logic perf_clr = 0;
  logic [15:0] stall_cnt, bubble_cnt;

  int errors = 0, checks = 0;

  id_exe_reg #(.WORD_LEN(WL), .EXE_CMD_LEN(CL), .REG_ADDR_LEN(RL)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
    .in_exe_cmd(in_exe_cmd), .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
    .in_val1(in_val1), .in_val2(in_val2), .in_st_val(in_st_val), .in_pc(in_pc),
    .out_valid(out_valid), .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en),
    .out_mem_w_en(out_mem_w_en), .out_exe_cmd(out_exe_cmd), .out_dest(out_dest),
    .out_src1(out_src1), .out_src2(out_src2), .out_val1(out_val1), .out_val2(out_val2),
    .out_st_val(out_st_val), .out_pc(out_pc)
`ifdef ID_EXE_PERF_EN
    , .perf_clr(perf_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifndef ID_EXE_PERF_EN
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

  always #5 clk = ~clk;

  // Reference model: the stage is one vector of fields; counters are plain saturating integers.
  logic [VW-1:0] exp_v, in_v, dut_v;
  int exp_stall = 0, exp_bubble = 0;

  assign in_v  = {1'b1, in_wb_en, in_mem_r_en, in_mem_w_en, in_exe_cmd, in_dest, in_src1, in_src2,
                  in_val1, in_val2, in_st_val, in_pc};
  assign dut_v = {out_valid, out_wb_en, out_mem_r_en, out_mem_w_en, out_exe_cmd, out_dest, out_src1,
                  out_src2, out_val1, out_val2, out_st_val, out_pc};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_v = '0; exp_stall = 0; exp_bubble = 0;
    end else begin
      if (perf_clr) begin
        exp_stall = 0; exp_bubble = 0;
      end else begin
        if (freeze && !flush) exp_stall = (exp_stall < 65535) ? exp_stall + 1 : 65535;
        if (flush || (!freeze && !in_valid)) exp_bubble = (exp_bubble < 65535) ? exp_bubble + 1 : 65535;
      end
      if (flush)        exp_v = '0;
      else if (!freeze) exp_v = in_valid ? in_v : '0;
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL stage_vs_model t=%0t got=%h exp=%h", $time, dut_v, exp_v);
      end
      checks++;
      if (!out_valid && (out_wb_en || out_mem_r_en || out_mem_w_en)) begin
        errors++;
        $display("FAIL side_effect_without_valid t=%0t wb=%b r=%b w=%b", $time, out_wb_en, out_mem_r_en, out_mem_w_en);
      end
`ifdef ID_EXE_PERF_EN
      checks++;
      if (stall_cnt !== 16'(exp_stall) || bubble_cnt !== 16'(exp_bubble)) begin
        errors++;
        $display("FAIL counters_vs_model t=%0t stall=%0d/%0d bubble=%0d/%0d", $time, stall_cnt, exp_stall, bubble_cnt, exp_bubble);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rand_in();
    in_wb_en = 1'($urandom); in_mem_r_en = 1'($urandom); in_mem_w_en = 1'($urandom);
    in_exe_cmd = CL'($urandom); in_dest = RL'($urandom); in_src1 = RL'($urandom); in_src2 = RL'($urandom);
    in_val1 = $urandom; in_val2 = $urandom; in_st_val = $urandom; in_pc = $urandom;
  endtask

  initial begin
    logic [15:0] s0, b0;
    #2;
    chk("reset_valid", 32'(out_valid), 0);
    chk("reset_val1", out_val1, 0);
    chk("reset_cmd", 32'(out_exe_cmd), 0);
    @(posedge clk); #1; rst = 0; cmp_en = 1;

    // Plain ADD load, one-cycle latency
    in_valid = 1; in_val1 = 5; in_val2 = 3; in_exe_cmd = ADD; in_wb_en = 1;
    in_mem_r_en = 0; in_mem_w_en = 0; in_dest = 5'd7; in_pc = 32'h100;
    step();
    chk("load_val1", out_val1, 5);
    chk("load_val2", out_val2, 3);
    chk("load_cmd", 32'(out_exe_cmd), 32'(ADD));
    chk("load_wb", 32'(out_wb_en), 1);
    chk("load_valid", 32'(out_valid), 1);
    chk("load_dest", 32'(out_dest), 7);

    // Freeze 3 cycles with changing inputs
    s0 = stall_cnt; b0 = bubble_cnt;
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      rand_in(); in_valid = 1'($urandom);
      step();
      chk("freeze_val1", out_val1, 5);
      chk("freeze_cmd", 32'(out_exe_cmd), 32'(ADD));
    end
`ifdef ID_EXE_PERF_EN
    chk("freeze_stall_inc", 32'(stall_cnt - s0), 3);
    chk("freeze_bubble_hold", 32'(bubble_cnt), 32'(b0));
`endif

    // Flush wins over freeze
    b0 = bubble_cnt; in_valid = 1; in_mem_w_en = 1; flush = 1;
    step();
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_mem_w", 32'(out_mem_w_en), 0);
    chk("flush_cmd", 32'(out_exe_cmd), 0);
`ifdef ID_EXE_PERF_EN
    chk("flush_bubble_inc", 32'(bubble_cnt - b0), 1);
`endif
    flush = 0; freeze = 0;

    // Invalid load becomes bubble
    in_valid = 0; in_wb_en = 1;
    step();
    chk("inv_wb", 32'(out_wb_en), 0);
    chk("inv_valid", 32'(out_valid), 0);

    // Both memory enables pass through
    in_valid = 1; in_mem_r_en = 1; in_mem_w_en = 1;
    step();
    chk("both_mem_r", 32'(out_mem_r_en), 1);
    chk("both_mem_w", 32'(out_mem_w_en), 1);

    // Mid-cycle asynchronous reset
    in_val1 = 32'h1234; in_exe_cmd = ADD; in_mem_w_en = 0;
    step();
    chk("pre_rst_val1", out_val1, 32'h1234);
    #1 rst = 1; #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_cmd", 32'(out_exe_cmd), 0);
    chk("async_rst_val1", out_val1, 0);
    #1 rst = 0;
    step();
    chk("post_rst_load", out_val1, 32'h1234);

    // Reset during stall discards held contents; next edge loads directly
    freeze = 1; step(); step();
    #1 rst = 1; #1;
    chk("stall_rst_val1", out_val1, 0);
    chk("stall_rst_stall_cnt", 32'(stall_cnt), 0);
    #1 rst = 0; freeze = 0; in_val1 = 32'hCAFE;
    step();
    chk("first_edge_load", out_val1, 32'hCAFE);
    chk("first_edge_valid", 32'(out_valid), 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_in();
      in_valid = ($urandom_range(0, 3) != 0);
      freeze   = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      perf_clr = ($urandom_range(0, 63) == 0);
      rst      = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0; flush = 0; freeze = 0; perf_clr = 0;

`ifdef ID_EXE_PERF_EN
    // Drive stall_cnt to FFFE, then saturate, then clear under freeze
    perf_clr = 1; step(); perf_clr = 0;
    chk("perf_clr_zero", 32'(stall_cnt), 0);
    freeze = 1;
    repeat (65534) step();
    chk("stall_preload", 32'(stall_cnt), 32'hFFFE);
    repeat (3) step();
    chk("stall_saturate", 32'(stall_cnt), 32'hFFFF);
    perf_clr = 1; step(); perf_clr = 0;
    chk("perf_clr_over_inc", 32'(stall_cnt), 0);
    chk("perf_clr_bubble", 32'(bubble_cnt), 0);
    freeze = 0;
`endif
    step();
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter WORD_LEN, default 32, data width of operands, store value and PC.
REQ-002 Parameter EXE_CMD_LEN, default 4, width of ALU command; value 0 is the NOP/default command.
REQ-003 Parameter REG_ADDR_LEN, default 5, register-file address width.
REQ-004 One clock; reset is asynchronous and active-high. Ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-005 freeze in 1, hold stage contents (hazard stall).
REQ-006 flush in 1, replace stage contents with a bubble (branch taken).
REQ-007 in_valid in 1; in_wb_en, in_mem_r_en, in_mem_w_en in 1 each; in_exe_cmd in EXE_CMD_LEN; in_dest, in_src1, in_src2 in REG_ADDR_LEN; in_val1, in_val2, in_st_val, in_pc in WORD_LEN; decode-stage fields.
REQ-008 out_valid, out_wb_en, out_mem_r_en, out_mem_w_en out 1; out_exe_cmd out EXE_CMD_LEN; out_dest, out_src1, out_src2 out REG_ADDR_LEN; out_val1, out_val2, out_st_val, out_pc out WORD_LEN; registered copies driving the ALU (A=out_val1, B=out_val2, ALUOp=out_exe_cmd) and forwarding unit.
REQ-009 With ID_EXE_PERF_EN only: perf_clr in 1; stall_cnt out 16; bubble_cnt out 16.

Function
REQ-010 All outputs shall be driven directly from flops; no combinational input-to-output path.
REQ-011 Update priority per rising clk edge shall be: flush > freeze > load.
REQ-012 Load (flush=0, freeze=0, in_valid=1): every out_* shall equal corresponding in_* one cycle later; out_valid=1; latency exactly 1 cycle.
REQ-013 Load with in_valid=0 shall load a bubble.
REQ-014 Bubble: out_valid, out_wb_en, out_mem_r_en, out_mem_w_en = 0; out_exe_cmd = 0; out_dest/src1/src2 = 0; all WORD_LEN outputs = 0.
REQ-015 flush=1 shall load a bubble regardless of freeze and in_valid.
REQ-016 freeze=1, flush=0 shall hold every output unchanged, including counters other than stall_cnt.
REQ-017 Side-effect enables (wb_en, mem_r_en, mem_w_en) shall never be 1 while out_valid=0.
REQ-018 in_mem_r_en and in_mem_w_en both 1 on load shall be passed through unchanged (decoder guarantees exclusivity; no correction here).

Reset
REQ-019 rst=1 shall immediately, without clock, force the bubble state of REQ-014 on all pipeline outputs.
REQ-020 rst shall override flush, freeze and load; rst asserted mid-stall shall discard held contents.
REQ-021 With ID_EXE_PERF_EN, rst shall clear stall_cnt and bubble_cnt to 0.
REQ-022 First clock edge after rst deassertion shall behave per REQ-011 with no extra dead cycle.

Configuration
REQ-023 Macro ID_EXE_PERF_EN defined: ports of REQ-009 exist and counters operate per REQ-024..REQ-026.
REQ-024 stall_cnt shall increment by 1 on each edge with freeze=1 and flush=0, saturating at 16'hFFFF.
REQ-025 bubble_cnt shall increment by 1 on each edge where a bubble is loaded (flush=1, or load with in_valid=0), saturating at 16'hFFFF.
REQ-026 perf_clr=1 shall synchronously clear both counters on that edge, overriding increment.
REQ-027 Macro undefined: REQ-009 ports and counter logic absent; pipeline behaviour identical bit-for-bit.

Verification
REQ-028 rst pulse mid-cycle with out_val1=32'h1234 held -> out_valid=0, out_exe_cmd=0, out_val1=0 before next edge.
REQ-029 Load in_val1=5, in_val2=3, in_exe_cmd=ADD, in_wb_en=1 -> next cycle out_val1=5, out_val2=3, out_exe_cmd=ADD, out_wb_en=1, out_valid=1.
REQ-030 freeze=1 for 3 cycles with new inputs applied -> outputs unchanged all 3 cycles; stall_cnt +3 (PERF build).
REQ-031 flush=1 and freeze=1 same edge, in_mem_w_en=1 -> bubble: out_valid=0, out_mem_w_en=0, out_exe_cmd=0; bubble_cnt +1.
REQ-032 Load with in_valid=0, in_wb_en=1 -> out_wb_en=0, out_valid=0.
REQ-033 PERF build: preload stall_cnt to 16'hFFFE, freeze 3 cycles -> stall_cnt=16'hFFFF; then perf_clr=1 with freeze=1 -> stall_cnt=0.
